uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 139 +++++++++++++
 tb/tb_uart_tx_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Four-requester round-robin byte scheduler feeding a single UART byte transmitter.
// Multi-byte frames hold the grant until the last byte; a stuck transmitter is abandoned after TIMEOUT_CYCLES.
module uart_tx_sched #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    input  logic [3:0]  req_last,
    output logic [3:0]  req_ready,
    output logic [7:0]  tx_data,
    output logic        tx_trig,
    input  logic        tx_done,
    output logic [1:0]  grant_id,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_TRIG = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

    state_t      r_state;
    state_t      w_state_next;
    logic [7:0]  r_tx_data;
    logic        r_last_flag;
    logic [1:0]  r_grant_id;
    logic        r_lock;
    logic [15:0] r_cnt;
    logic        r_done_prev;

    logic [7:0]  w_lane [4];
    logic [3:0]  w_eligible;
    logic        w_found;
    logic [1:0]  w_winner;
    logic        w_edge;
    logic        w_timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_lane[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // While a frame is open only its owner (the last grant) may continue.
    assign w_eligible    = r_lock ? (req_valid & (4'b0001 << r_grant_id)) : req_valid;
    assign w_edge        = tx_done & ~r_done_prev;
    assign w_timeout_hit = (r_cnt == TIMEOUT_VAL);

    always_comb begin
        logic [1:0] idx;
        idx      = 2'd0;
        w_found  = 1'b0;
        w_winner = r_grant_id;
        for (int k = 1; k <= 4; k++) begin
            idx = r_grant_id + 2'(k);
            if (!w_found && w_eligible[idx]) begin
                w_found  = 1'b1;
                w_winner = idx;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 4'b0000;
        timeout_err  = 1'b0;
        case (r_state)
            ST_ARB: begin
                if (w_found) begin
                    req_ready    = 4'b0001 << w_winner;
                    w_state_next = ST_TRIG;
                end
            end
            ST_TRIG: w_state_next = ST_WAIT;
            ST_WAIT: begin
                // A completion edge in the timeout cycle still counts as success.
                if (w_edge) begin
                    w_state_next = ST_ARB;
                end else if (w_timeout_hit) begin
                    timeout_err  = 1'b1;
                    w_state_next = ST_ARB;
                end
            end
            default: w_state_next = ST_ARB;
        endcase
        if (rst) begin
            req_ready   = 4'b0000;
            timeout_err = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ARB;
            r_tx_data   <= 8'h00;
            r_last_flag <= 1'b0;
            r_grant_id  <= 2'd3;
            r_lock      <= 1'b0;
            r_cnt       <= 16'd0;
            r_done_prev <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_done_prev <= tx_done;
            case (r_state)
                ST_ARB: begin
                    if (w_found) begin
                        r_tx_data   <= w_lane[w_winner];
                        r_last_flag <= req_last[w_winner];
                        r_grant_id  <= w_winner;
                    end
                end
                ST_TRIG: r_cnt <= 16'd0;
                ST_WAIT: begin
                    if (w_edge) begin
                        r_lock <= ~r_last_flag;
                    end else if (w_timeout_hit) begin
                        r_lock <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx_data  = r_tx_data;
    assign grant_id = r_grant_id;
    assign tx_trig  = (r_state == ST_TRIG) && !rst;
    assign busy     = (r_state == ST_TRIG) || (r_state == ST_WAIT);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched: a transaction-level model of the scheduling rules
// predicts grants, trigger timing, completions and timeouts every cycle.
module tb_uart_tx_sched;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data;
    logic        tx_trig;
    logic        tx_done;
    logic [1:0]  grant_id;
    logic        busy;
    logic        timeout_err;

    always #5 clk = ~clk;

    uart_tx_sched #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_trig(tx_trig),
        .tx_done(tx_done), .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // reference model: one send in flight at a time, timed from its grant cycle
    bit         in_flight = 0;
    int         grant_cyc = 0;
    int         m_gid     = 3;
    bit         m_lock    = 0;
    bit         m_lastf   = 0;
    logic [7:0] m_byte    = 8'h00;
    bit         done_prev = 0;

    // transmitter model
    int hi_cnt = 0;
    bit pend = 0;
    int rise_at = 0;
    int force_delay = 0;   // 0: random, <0: never answers, >0: fixed delay

    logic [3:0]  v_valid = 4'h0;
    logic [3:0]  v_last  = 4'h0;
    logic [31:0] v_data  = 32'h0;
    bit          v_rst   = 0;

    logic [3:0] s_ready;
    logic       s_trig, s_busy, s_tmo;
    logic [7:0] s_data;
    logic [1:0] s_gid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic run_cycle();
        bit d;
        bit found;
        int w;
        int age;
        logic [3:0] elig;
        logic [3:0] exp_ready;
        bit exp_trig, exp_busy, exp_tmo;

        if (v_rst) begin
            d = 0; hi_cnt = 0; pend = 0;
        end else if (hi_cnt > 0) begin
            d = 1; hi_cnt--;
        end else if (pend && cyc >= rise_at && !done_prev) begin
            d = 1; hi_cnt = $urandom_range(0, 5); pend = 0;
        end else begin
            d = 0;
        end
        rst = v_rst; req_valid = v_valid; req_data = v_data; req_last = v_last; tx_done = d;

        @(negedge clk);
        s_ready = req_ready; s_trig = tx_trig; s_busy = busy;
        s_tmo = timeout_err; s_data = tx_data; s_gid = grant_id;

        exp_ready = 4'h0; exp_trig = 0; exp_tmo = 0;
        exp_busy = in_flight && (cyc > grant_cyc);
        chk("grant_id", 32'(s_gid), 32'(m_gid));
        chk("tx_data", 32'(s_data), 32'(m_byte));

        if (!v_rst) begin
            if (!in_flight) begin
                elig  = m_lock ? (v_valid & (4'b0001 << m_gid)) : v_valid;
                found = 0;
                w     = 0;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && elig[(m_gid + k) % 4]) begin
                        found = 1;
                        w = (m_gid + k) % 4;
                    end
                end
                if (found) begin
                    exp_ready = 4'b0001 << w;
                    in_flight = 1; grant_cyc = cyc;
                    m_byte = v_data[8*w +: 8]; m_lastf = v_last[w]; m_gid = w;
                end
            end else if (cyc == grant_cyc + 1) begin
                exp_trig = 1;
            end else begin
                age = cyc - grant_cyc - 2;
                if (d && !done_prev) begin
                    m_lock = !m_lastf; in_flight = 0;
                end else if (age == TMO) begin
                    exp_tmo = 1; m_lock = 0; in_flight = 0;
                end
            end
        end
        chk("req_ready", 32'(s_ready), 32'(exp_ready));
        chk("tx_trig", 32'(s_trig), 32'(exp_trig));
        chk("busy", 32'(s_busy), 32'(exp_busy));
        chk("timeout_err", 32'(s_tmo), 32'(exp_tmo));

        if (v_rst) begin
            in_flight = 0; m_gid = 3; m_byte = 8'h00; m_lock = 0;
        end
        if (s_trig) begin
            if (force_delay < 0) begin
                pend = 0;
            end else if (force_delay > 0) begin
                pend = 1; rise_at = cyc + force_delay;
            end else if ($urandom_range(0, 5) == 0) begin
                pend = 0;
            end else begin
                pend = 1; rise_at = cyc + $urandom_range(1, 20);
            end
        end
        done_prev = d;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t_trig;
        int t_tmo;

        rst = 1; req_valid = 0; req_data = 0; req_last = 0; tx_done = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset state (checked by the model inside run_cycle)
        run_cycle();

        // single byte from requester 2
        force_delay = 5;
        v_valid = 4'b0100; v_data = 32'h00A5_0000; v_last = 4'b0100;
        run_cycle();
        chk("single_ready", 32'(s_ready), 32'h4);
        v_valid = 4'b0000;
        run_cycle();
        chk("single_trig", 32'(s_trig), 32'h1);
        chk("single_data", 32'(s_data), 32'hA5);
        chk("single_gid", 32'(s_gid), 32'h2);
        for (int i = 0; i < 40 && s_busy; i++) run_cycle();
        chk("single_idle", 32'(s_busy), 32'h0);

        // timeout with a silent transmitter, then the next requester is served
        force_delay = -1;
        v_valid = 4'b0001; v_last = 4'b0001; v_data = 32'h0000_003C;
        t_trig = -1; t_tmo = -1;
        for (int i = 0; i < 60 && t_tmo < 0; i++) begin
            run_cycle();
            v_valid = 4'b0000;
            if (s_trig) t_trig = cyc - 1;
            if (s_tmo) t_tmo = cyc - 1;
        end
        chk("tmo_seen", 32'(t_tmo >= 0), 32'h1);
        chk("tmo_delay", 32'(t_tmo - t_trig - 1), 32'(TMO));
        v_valid = 4'b1000; v_last = 4'b1000;
        run_cycle();
        chk("tmo_next_ready", 32'(s_ready), 32'h8);

        // reset in the middle of a wait
        for (int i = 0; i < 6; i++) begin
            v_valid = 4'b0000;
            run_cycle();
        end
        chk("rstw_busy_before", 32'(s_busy), 32'h1);
        v_rst = 1;
        run_cycle();
        chk("rstw_no_tmo", 32'(s_tmo), 32'h0);
        v_rst = 0;
        run_cycle();
        chk("rstw_busy", 32'(s_busy), 32'h0);
        chk("rstw_gid", 32'(s_gid), 32'h3);
        chk("rstw_trig", 32'(s_trig), 32'h0);

        // randomized traffic: frames, stale done levels, late answers and resets
        force_delay = 0;
        for (int i = 0; i < 4000; i++) begin
            v_valid = 4'($urandom_range(0, 15));
            v_data  = $urandom;
            v_last  = 4'($urandom_range(0, 15));
            v_rst   = in_flight && ($urandom_range(0, 149) == 0);
            run_cycle();
        end
        v_rst = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
